// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter/normalizer datapath.
//   - state_e : normalizer FSM encodings (idle plus one state per search step)
//   - DirLeft / DirRight : direction encodings for the dir input
//   - DataW / CntW : datapath and count widths
//   - ZeroCnt : count reported for an all-zero operand
package shifter_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = 5;

  localparam logic DirLeft  = 1'b0;
  localparam logic DirRight = 1'b1;

  localparam logic [CntW-1:0] ZeroCnt = 5'd16;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    St8    = 3'd1,
    St4    = 3'd2,
    St2    = 3'd3,
    St1    = 3'd4
  } state_e;

endpackage

// File: rtl/norm_stage.sv
// One binary-search normalization step of fixed amount AMT (combinational).
//   w       : working word
//   dir     : 0 = left (test top AMT bits), 1 = right (test bottom AMT bits)
//   shifted : w shifted by AMT (zero fill) when the step is taken, else w
//   taken   : the tested AMT-bit field was all zero
module norm_stage
  import shifter_pkg::*;
#(
  parameter int unsigned AMT = 1
) (
  input  logic [DataW-1:0] w,
  input  logic             dir,
  output logic [DataW-1:0] shifted,
  output logic             taken
);

  always_comb begin
    if (dir == DirRight) begin
      taken   = (w[AMT-1:0] == '0);
      shifted = taken ? (w >> AMT) : w;
    end else begin
      taken   = (w[DataW-1 -: AMT] == '0);
      shifted = taken ? (w << AMT) : w;
    end
  end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle 16-bit normalizer: shifts the first set bit to the MSB (left)
// or LSB (right) using a 4-step binary search (8, 4, 2, 1), one step per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, dir : request (sampled only when idle) and direction (0 left, 1 right)
//   In         : operand, latched with an accepted start
//   Out, Cnt   : normalized word and shift count (16 for a zero operand)
//   busy       : operation in flight
//   done       : one-cycle pulse when Out/Cnt are updated
module shift_normalizer
  import shifter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [DataW-1:0] In,
  output logic [DataW-1:0] Out,
  output logic [CntW-1:0]  Cnt,
  output logic             busy,
  output logic             done
);

  state_e            state_q, state_d;
  logic [DataW-1:0]  w_q, w_d;
  logic [CntW-1:0]   acc_q, acc_d;
  logic              zero_q, zero_d;
  logic              dir_q, dir_d;
  logic [DataW-1:0]  out_q, out_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [DataW-1:0]  w8, w4, w2, w1;
  logic              t8, t4, t2, t1;

  // All four stages look at the same working word; the state picks one.
  norm_stage #(.AMT(8)) u_stage8 (.w(w_q), .dir(dir_q), .shifted(w8), .taken(t8));
  norm_stage #(.AMT(4)) u_stage4 (.w(w_q), .dir(dir_q), .shifted(w4), .taken(t4));
  norm_stage #(.AMT(2)) u_stage2 (.w(w_q), .dir(dir_q), .shifted(w2), .taken(t2));
  norm_stage #(.AMT(1)) u_stage1 (.w(w_q), .dir(dir_q), .shifted(w1), .taken(t1));

  logic [DataW-1:0] step_w;
  logic             step_take;
  logic [CntW-1:0]  step_amt;

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    acc_d     = acc_q;
    zero_d    = zero_q;
    dir_d     = dir_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    step_w    = w_q;
    step_take = 1'b0;
    step_amt  = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_d     = In;
          dir_d   = dir;
          zero_d  = (In == '0);
          acc_d   = '0;
          state_d = St8;
        end
      end
      St8: begin
        step_w    = w8;
        step_take = t8;
        step_amt  = 5'd8;
        state_d   = St4;
      end
      St4: begin
        step_w    = w4;
        step_take = t4;
        step_amt  = 5'd4;
        state_d   = St2;
      end
      St2: begin
        step_w    = w2;
        step_take = t2;
        step_amt  = 5'd2;
        state_d   = St1;
      end
      St1: begin
        step_w    = w1;
        step_take = t1;
        step_amt  = 5'd1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      w_d   = step_w;
      acc_d = step_take ? (acc_q + step_amt) : acc_q;
    end

    // Completion uses the post-step values; a zero operand reports 16 / 0.
    if (state_q == St1) begin
      done_d = 1'b1;
      out_d  = zero_q ? '0 : w_d;
      cnt_d  = zero_q ? ZeroCnt : acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      w_q     <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      dir_q   <= DirLeft;
      out_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign Out  = out_q;
  assign Cnt  = cnt_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Multi-cycle normalizer that undoes what the shifter applies. Given a 16-bit word, it finds the shift that brings the first set bit to the MSB (left mode) or to the LSB (right mode). It returns the normalized word and the shift count, so downstream logic can drive the shifter with the inverse amount. It sits beside the shifter in the execute stage and is used by the multi-cycle normalize and count-leading/trailing-zero paths.

## Interface
- Parameters: none. The datapath is fixed at 16 bits, with a 5-bit count.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. Sampled only when `busy`=0.
- `dir`  in  1  0 = left (leading zeros, logical shift left); 1 = right (trailing zeros, logical shift right).
- `In`  in  16  operand. Sampled together with an accepted `start`.
- `Out`  out  16  normalized word. Held until the next completion.
- `Cnt`  out  5  shift count, range 0..16.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when `Out`/`Cnt` are updated.

## Operation
- **State machine:** IDLE → S8 → S4 → S2 → S1 → IDLE.
  - Each S*k* state performs one binary-search step of amount *k*.
- **Accept:** in IDLE, `start`=1 latches `In` into the working register `w`, latches `dir`, and sets `zero = (In==0)` and `acc=0`.
- **Step k, left mode:** if `w[15:16-k]==0`, then `w <= w<<k` and `acc <= acc+k`; otherwise `w` and `acc` hold.
- **Step k, right mode:** if `w[k-1:0]==0`, then `w <= w>>k` and `acc <= acc+k`; otherwise both hold.
- **Fill:** vacated bits are filled with 0 in both modes. There is no rotation.
- **Completion (S1 → IDLE):**
  - `Out` gets the post-step `w`.
  - `Cnt` gets the post-step `acc`, except that `zero`=1 forces `Cnt`=16 and `Out`=0.
  - `done`=1 for exactly that one cycle.
- **Width rule:** `acc` is 5 bits. For nonzero input, steps sum to at most 15, so no overflow is possible.
- `start` while `busy`=1 is ignored. It has no effect on the operation in flight or on the next result.
- `dir` and `In` changes while busy are ignored, because both are latched at accept.

## Timing
- Let the accepting edge be E0.
- Steps 8, 4, 2 and 1 execute at edges E1 through E4.
- `Out`, `Cnt` and `done` become valid after E4. Latency is 4 cycles from accept to result.
- `busy` is 1 from after E0 through E4, and 0 in the cycle where `done`=1.
- Back-to-back: a `start` in the `done` cycle is accepted. Throughput is one operation per 5 cycles.
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `Out`=16'h0000, `Cnt`=0; internal `w`, `acc` and `zero` are cleared.
- **Reset mid-operation:**
  - Asserting `rst_n` low aborts immediately and asynchronously.
  - No `done` is produced, and the previous `Out`/`Cnt` are cleared.
  - After release, the block waits in IDLE for a fresh `start`.

## Structure
- **Shared package `shifter_pkg`:**
  - state encodings: IDLE, S8, S4, S2, S1;
  - direction constants: DIR_LEFT=0, DIR_RIGHT=1;
  - count width: 5;
  - zero-input count: 16.
- **Sub-module `norm_stage`:** purely combinational, parameter `AMT`.
  - Inputs: `w`, `dir`.
  - Outputs: shifted `w`, taken flag.
  - The top level instantiates it for AMT=8, 4, 2 and 1, and muxes the result by state, so one step applies per cycle.
  - The FSM, `acc` and result registers live in `shift_normalizer`.

## Test plan
- Left mode, `In`=16'h0001, `start` pulse → after 4 cycles `done`=1, `Out`=16'h8000, `Cnt`=15; `busy` high for exactly 4 cycles.
- Left mode, `In`=16'h00F0 → `Out`=16'hF000, `Cnt`=8. Left mode, `In`=16'h8000 → `Out`=16'h8000, `Cnt`=0.
- Right mode, `In`=16'h8000 → `Out`=16'h0001, `Cnt`=15. Right mode, `In`=16'h0A00 → `Out`=16'h0005, `Cnt`=9.
- `In`=16'h0000 in either mode → `Out`=16'h0000, `Cnt`=16, `done` pulses once.
- **Busy and back-to-back:** run left 16'h0001. Assert `start` with `In`=16'h1234 in cycles E1–E3 → ignored, result is still 16'h8000/15. Then `start` with right 16'h0010 in the `done` cycle → accepted, 4 cycles later `Out`=16'h0001, `Cnt`=4.
- **Reset mid-operation:** drop `rst_n` at E2 → `busy`=0, `Out`=0, `Cnt`=0 immediately, no `done`. Release, then left 16'h0100 → `Out`=16'h8000, `Cnt`=7.
